// File: rtl/frequency_divider_1hz.sv
// Divides clk_100MHz down to a 50%-duty square wave on clk_1Hz.
// Also keeps a 4-digit packed BCD count of clk_1Hz rising edges.
module frequency_divider_1hz #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OUT_FREQ_HZ = 1
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    output logic        clk_1Hz,
    output logic [15:0] count_bcd
);

    localparam int unsigned DIVISOR = (OUT_FREQ_HZ == 0) ? 1 : 2 * OUT_FREQ_HZ;
    localparam int unsigned HALF    = CLK_FREQ_HZ / DIVISOR;
    localparam int unsigned CNT_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);

    generate
        if ((OUT_FREQ_HZ == 0) || (HALF < 1) || ((CLK_FREQ_HZ % DIVISOR) != 0)) begin : g_bad_params
            $error("frequency_divider_1hz: CLK_FREQ_HZ must be a nonzero multiple of 2*OUT_FREQ_HZ");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    // Ripple-carry BCD increment; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (result[d*4 +: 4] == 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = result[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_1Hz   <= 1'b0;
            count_bcd <= 16'h0000;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk_1Hz <= ~clk_1Hz;
            // Count only the low-to-high toggle, in the same cycle as the rise.
            if (!clk_1Hz) begin
                count_bcd <= bcd_inc(count_bcd);
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_frequency_divider_1hz.sv
// Directed bench for frequency_divider_1hz with three divide ratios
// (HALF=10, HALF=50, HALF=1) sharing one clock and reset.
module tb_frequency_divider_1hz;

    logic        clk;
    logic        rst_n;
    logic        clk_a, clk_b, clk_c;
    logic [15:0] bcd_a, bcd_b, bcd_c;

    int n_checks = 0;
    int n_fail   = 0;

    // HALF = 10
    frequency_divider_1hz #(.CLK_FREQ_HZ(20), .OUT_FREQ_HZ(1)) dut_a (
        .clk_100MHz(clk), .rst_n(rst_n), .clk_1Hz(clk_a), .count_bcd(bcd_a)
    );
    // HALF = 50
    frequency_divider_1hz #(.CLK_FREQ_HZ(100_000_000), .OUT_FREQ_HZ(1_000_000)) dut_b (
        .clk_100MHz(clk), .rst_n(rst_n), .clk_1Hz(clk_b), .count_bcd(bcd_b)
    );
    // HALF = 1: one output period every 2 cycles, so the BCD wrap is reachable quickly
    frequency_divider_1hz #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut_c (
        .clk_100MHz(clk), .rst_n(rst_n), .clk_1Hz(clk_c), .count_bcd(bcd_c)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sample 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic bad_nibble(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    initial begin
        rst_n = 1'b0;

        // Reset held for 5 cycles: outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_clk_a", 32'(clk_a), 32'd0);
            check("rst_bcd_a", 32'(bcd_a), 32'h0000);
            check("rst_clk_c", 32'(clk_c), 32'd0);
            check("rst_bcd_c", 32'(bcd_c), 32'h0000);
        end

        // Free run. After counted edge e:
        //   HALF=10: clk=(e/10)%2, rises=(e+10)/20
        //   HALF=50: clk=(e/50)%2, rises=(e+50)/100
        //   HALF=1 : clk=e%2,      rises=(e+1)/2, BCD wraps every 10000 rises
        release_reset();
        for (int e = 1; e <= 20000; e++) begin
            tick();
            if (e <= 2000) begin
                check("a_clk", 32'(clk_a), 32'((e / 10) % 2));
                check("a_bcd", 32'(bcd_a), 32'(to_bcd((e + 10) / 20)));
            end
            if (e <= 400) begin
                check("b_clk", 32'(clk_b), 32'((e / 50) % 2));
                check("b_bcd", 32'(bcd_b), 32'(to_bcd((e + 50) / 100)));
            end
            check("c_clk", 32'(clk_c), 32'(e % 2));
            check("c_bcd", 32'(bcd_c), 32'(to_bcd(((e + 1) / 2) % 10000)));
            check("c_nibble", 32'(bad_nibble(bcd_c)), 32'd0);
            // Hand-computed anchor points
            if (e == 10)    check("a_rise1",    32'(bcd_a), 32'h0001);
            if (e == 170)   check("a_rise9",    32'(bcd_a), 32'h0009);
            if (e == 190)   check("a_rise10",   32'(bcd_a), 32'h0010);
            if (e == 1990)  check("a_rise100",  32'(bcd_a), 32'h0100);
            if (e == 300)   check("b_300cyc",   32'(bcd_b), 32'h0003);
            if (e == 19997) check("c_rise9999", 32'(bcd_c), 32'h9999);
            if (e == 19999) check("c_wrap",     32'(bcd_c), 32'h0000);
        end

        // Mid-operation reset: restart, run to edge 15 (HALF=10 high, count 1),
        // then drop rst_n between edges and check clear before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        release_reset();
        for (int e = 1; e <= 15; e++) tick();
        check("pre_rst_clk_a", 32'(clk_a), 32'd1);
        check("pre_rst_bcd_a", 32'(bcd_a), 32'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clk_a", 32'(clk_a), 32'd0);
        check("async_bcd_a", 32'(bcd_a), 32'h0000);
        check("async_clk_c", 32'(clk_c), 32'd0);
        check("async_bcd_c", 32'(bcd_c), 32'h0000);
        tick();
        check("held_clk_a", 32'(clk_a), 32'd0);
        release_reset();
        for (int e = 1; e <= 30; e++) begin
            tick();
            check("post_clk_a", 32'(clk_a), 32'((e / 10) % 2));
            check("post_bcd_a", 32'(bcd_a), 32'(to_bcd((e + 10) / 20)));
            if (e == 9)  check("post_e9_clk_a",  32'(clk_a), 32'd0);
            if (e == 10) check("post_e10_bcd_a", 32'(bcd_a), 32'h0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
